// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block/stream types and FSM state encoding
package aes_pkg;

   localparam int WORD      = 32;
   localparam int NB        = 4;
   localparam int BLK       = WORD * NB;
   localparam int BLK_BYTES = BLK / 8;

   typedef logic [BLK-1:0]       block_t;
   typedef logic [BLK_BYTES-1:0] strb_t;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/aes_axis_packer.sv
// rtl/aes_axis_packer.sv - packs a narrow AXI4-Stream into zero-padded AES blocks
// Optional AES_PACKER_PIPE_EN: accumulator keeps filling while the output block is held.
module aes_axis_packer
   import aes_pkg::*;
#(
   parameter int WORD = 32,
   parameter int NB   = 4,
   parameter int IW   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_axi4s_tvalid,
   output logic                   s_axi4s_tready,
   input  logic [IW-1:0]          s_axi4s_tdata,
   input  logic [IW/8-1:0]        s_axi4s_tstrb,
   input  logic                   s_axi4s_tlast,
   output logic                   m_axi4s_tvalid,
   input  logic                   m_axi4s_tready,
   output logic [WORD*NB-1:0]     m_axi4s_tdata,
   output logic [WORD*NB/8-1:0]   m_axi4s_tstrb,
   output logic                   m_axi4s_tlast
);

   localparam int P_BLK   = WORD * NB;
   localparam int P_BLKB  = P_BLK / 8;
   localparam int P_SW    = IW / 8;
   localparam int P_BEATS = P_BLK / IW;
   localparam int P_CW    = (P_BEATS > 1) ? $clog2(P_BEATS) : 1;

   generate
      if ((IW % 8) != 0 || (P_BLK % IW) != 0) begin : g_bad_cfg
         $error("aes_axis_packer: IW must be a multiple of 8 and divide WORD*NB");
      end
   endgenerate

   logic               r_run;
   state_t             r_state;
   state_t             w_state_nxt;
   logic [P_CW-1:0]    r_cnt;
   logic [P_BLK-1:0]   r_acc_data;
   logic [P_BLKB-1:0]  r_acc_strb;
   logic [P_BLK-1:0]   w_acc_data;
   logic [P_BLKB-1:0]  w_acc_strb;
   logic               r_m_valid;
   logic [P_BLK-1:0]   r_m_data;
   logic [P_BLKB-1:0]  r_m_strb;
   logic               r_m_last;
   logic               w_s_ready;
   logic               w_s_fire;
   logic               w_last_slot;
   logic               w_done;
   logic               w_m_fire;
   logic               w_m_load;
   logic               w_m_clear;

   assign w_last_slot = (r_cnt == P_CW'(P_BEATS - 1));

`ifdef AES_PACKER_PIPE_EN
   // Only a block-completing beat must wait for the output register to free up.
   assign w_s_ready = r_run && !((w_last_slot || s_axi4s_tlast) && r_m_valid && !m_axi4s_tready);
`else
   assign w_s_ready = r_run && (r_state == FILL);
`endif

   assign w_s_fire = s_axi4s_tvalid && w_s_ready;
   assign w_done   = w_s_fire && (w_last_slot || s_axi4s_tlast);
   assign w_m_fire = r_m_valid && m_axi4s_tready;

   // Accumulator image with the current beat dropped into its slot (slot 0 = MSB).
   always_comb begin
      w_acc_data = r_acc_data;
      w_acc_strb = r_acc_strb;
      for (int k = 0; k < P_BEATS; k++) begin
         if (r_cnt == P_CW'(k)) begin
            w_acc_data[P_BLK-1-k*IW -: IW]    = s_axi4s_tdata;
            w_acc_strb[P_BLKB-1-k*P_SW -: P_SW] = s_axi4s_tstrb;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_m_load    = 1'b0;
      w_m_clear   = 1'b0;
      case (r_state)
         FILL: begin
            if (w_done) begin
               w_m_load    = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
`ifdef AES_PACKER_PIPE_EN
            if (w_done) begin
               w_m_load = 1'b1;
            end else if (w_m_fire) begin
               w_m_clear   = 1'b1;
               w_state_nxt = FILL;
            end
`else
            if (w_m_fire) begin
               w_m_clear   = 1'b1;
               w_state_nxt = FILL;
            end
`endif
         end
         default: w_state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run   <= 1'b0;
         r_state <= FILL;
      end else begin
         r_run   <= 1'b1;
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_acc_data <= '0;
         r_acc_strb <= '0;
      end else if (w_done) begin
         r_cnt      <= '0;
         r_acc_data <= '0;
         r_acc_strb <= '0;
      end else if (w_s_fire) begin
         r_cnt      <= r_cnt + P_CW'(1);
         r_acc_data <= w_acc_data;
         r_acc_strb <= w_acc_strb;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_strb  <= '0;
         r_m_last  <= 1'b0;
      end else if (w_m_load) begin
         r_m_valid <= 1'b1;
         r_m_data  <= w_acc_data;
         r_m_strb  <= w_acc_strb;
         r_m_last  <= s_axi4s_tlast;
      end else if (w_m_clear) begin
         r_m_valid <= 1'b0;
      end
   end

   assign s_axi4s_tready = w_s_ready;
   assign m_axi4s_tvalid = r_m_valid;
   assign m_axi4s_tdata  = r_m_data;
   assign m_axi4s_tstrb  = r_m_strb;
   assign m_axi4s_tlast  = r_m_last;

endmodule
